// File: rtl/mem_bus_ctrl_pkg.sv
// Shared widths, FSM state encoding and timer width for the data-memory bus controller.
package mem_bus_ctrl_pkg;

    localparam int REG_DATA_WIDTH  = 32;
    localparam int BYTE_SLCT_WIDTH = 4;
    localparam int TMR_WIDTH       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/mem_bus_timer.sv
// Loadable 8-bit up-counter with clear and enable; flags the last permitted wait cycle.
module mem_bus_timer
    import mem_bus_ctrl_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic [TMR_WIDTH-1:0] i_load_val,
    output logic                 o_expired
);

    logic [TMR_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted during the LIMIT-th enabled cycle, so the abort edge ends exactly LIMIT cycles.
    assign o_expired = (r_count == TMR_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle data-memory access controller between the MEM stage and a req/ack bus.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = REG_DATA_WIDTH,
    parameter int BE_WIDTH       = BYTE_SLCT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReadMem,
    input  logic                  WriteMem,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [BE_WIDTH-1:0]   byte_slct,
    input  logic [DATA_WIDTH-1:0] data_to_write_mem,
    output logic [DATA_WIDTH-1:0] raw_mem_data,
    output logic                  mem_stall,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [BE_WIDTH-1:0]   bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic [1:0]            dbg_state
);

    bus_state_t            r_state, w_state_nxt;
    logic                  r_bus_req, r_bus_we, r_bus_err;
    logic [DATA_WIDTH-1:0] r_bus_addr, r_bus_wdata, r_raw;
    logic [BE_WIDTH-1:0]   r_bus_be;
    logic                  w_acc, w_start, w_finish, w_timeout, w_expired;

    assign w_acc = (ReadMem | WriteMem) & (|byte_slct);

    mem_bus_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start),
        .i_en       (r_state == REQ),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_expired  (w_expired)
    );

    // Bus handshake: bus_req rises with all bus fields and holds them until the single-cycle
    // bus_ack is seen in REQ; an ack arriving on the timeout cycle still completes normally.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_raw       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= WriteMem;
                r_bus_addr  <= mem_addr & ~DATA_WIDTH'(3);
                r_bus_be    <= byte_slct;
                r_bus_wdata <= data_to_write_mem;
            end else if (w_finish || w_timeout) begin
                r_bus_req <= 1'b0;
            end
            // A timed-out load returns zero rather than stale data.
            if (w_finish && !r_bus_we) begin
                r_raw <= bus_rdata;
            end else if (w_timeout && !r_bus_we) begin
                r_raw <= '0;
            end
        end
    end

    // Gated by rst so an asserted reset releases the pipeline even with a request pending.
    assign mem_stall    = rst & (((r_state == IDLE) & w_acc) | (r_state == REQ));
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_err      = r_bus_err;
    assign bus_addr     = r_bus_addr;
    assign bus_be       = r_bus_be;
    assign bus_wdata    = r_bus_wdata;
    assign raw_mem_data = r_raw;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: transaction-level model feeding an expected queue.
module tb_mem_bus_ctrl;

    localparam int TIMEOUT = 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        stall;
        logic        err;
        logic [31:0] raw;
        logic [1:0]  st;
        logic        chk_bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReadMem, WriteMem, bus_ack;
    logic [31:0] mem_addr, data_to_write_mem, bus_rdata;
    logic [3:0]  byte_slct;
    logic [31:0] raw_mem_data, bus_addr, bus_wdata;
    logic        mem_stall, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [1:0]  dbg_state;

    exp_t        exp_q[$];
    logic [31:0] m_raw;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cnt = 0;
    int          err_cnt   = 0;
    int          req_rises = 0;
    logic        prev_req  = 1'b0;

    mem_bus_ctrl #(
        .DATA_WIDTH(32), .BE_WIDTH(4), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ReadMem(ReadMem), .WriteMem(WriteMem),
        .mem_addr(mem_addr), .byte_slct(byte_slct), .data_to_write_mem(data_to_write_mem),
        .raw_mem_data(raw_mem_data), .mem_stall(mem_stall), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process: one queue entry per cycle whose outputs are meaningful
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("bus_req", {31'd0, bus_req}, {31'd0, e.req});
                check("mem_stall", {31'd0, mem_stall}, {31'd0, e.stall});
                check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                check("raw_mem_data", raw_mem_data, e.raw);
                check("state", {30'd0, dbg_state}, {30'd0, e.st});
                if (e.chk_bus) begin
                    check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                    check("bus_wdata", bus_wdata, e.wdata);
                end
            end
        end
    end

    // Event counters used by the hand-computed literal checks
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_stall) stall_cnt++;
            if (bus_err) err_cnt++;
            if (bus_req && !prev_req) req_rises++;
            prev_req = bus_req;
        end
    end

    // Driver tasks
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic ack,
                        input logic [31:0] rdata, input exp_t e);
        @(negedge clk);
        ReadMem = rd;  WriteMem = wr;  mem_addr = addr;  byte_slct = be;
        data_to_write_mem = wd;  bus_ack = ack;  bus_rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic stray_ack);
        exp_t e;
        e = '0;
        e.raw = m_raw;
        e.st  = S_IDLE;
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, stray_ack, 32'h5A5A5A5A, e);
    endtask

    // ack_at: REQ cycle (1-based) on which the slave acks; 0 means never
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rdata, input logic stray_done);
        exp_t e;
        logic acc;
        logic to;
        acc = (rd | wr) && (be != 4'h0);
        to  = 1'b0;
        stall_cnt = 0;
        err_cnt   = 0;
        e = '0;
        e.raw   = m_raw;
        e.st    = S_IDLE;
        e.stall = acc;
        step(rd, wr, addr, be, wd, 1'b0, 32'h0, e);
        if (!acc) return;
        for (int k = 1; k <= TIMEOUT; k++) begin
            logic ack;
            ack = (k == ack_at);
            e = '0;
            e.req = 1'b1;  e.we = wr;  e.addr = addr & ~32'h3;  e.be = be;  e.wdata = wd;
            e.chk_bus = 1'b1;  e.stall = 1'b1;  e.st = S_REQ;  e.raw = m_raw;
            step(rd, wr, addr, be, wd, ack, rdata, e);
            if (ack) begin
                if (!wr) m_raw = rdata;
                break;
            end
            if (k == TIMEOUT) begin
                to = 1'b1;
                if (!wr) m_raw = 32'h0;
            end
        end
        e = '0;
        e.st  = S_DONE;
        e.err = to;
        e.raw = m_raw;
        step(rd, wr, addr, be, wd, stray_done, 32'hDEADBEEF, e);
    endtask

    // Stimulus
    initial begin
        rst = 1'b0;
        ReadMem = 0;  WriteMem = 0;  mem_addr = 0;  byte_slct = 0;
        data_to_write_mem = 0;  bus_ack = 0;  bus_rdata = 0;
        m_raw = 32'h0;
        #3;
        check("reset bus_req", {31'd0, bus_req}, 32'd0);
        check("reset mem_stall", {31'd0, mem_stall}, 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset raw_mem_data", raw_mem_data, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        #9;
        rst = 1'b1;
        idle(1'b0);

        // Zero-wait load
        access(1'b1, 1'b0, 32'h1003, 4'b0001, 32'h0, 1, 32'hA1B2C3D4, 1'b0);
        #3;
        check("load stall cycles", stall_cnt, 32'd2);
        check("load raw literal", raw_mem_data, 32'hA1B2C3D4);
        idle(1'b1);

        // Store with 3 wait states; ack lands on the timeout cycle and must win
        access(1'b0, 1'b1, 32'h20, 4'b1100, 32'hBEEF0000, 4, 32'h12345678, 1'b0);
        #3;
        check("store stall cycles", stall_cnt, 32'd5);
        check("store err count", err_cnt, 32'd0);
        check("store raw literal", raw_mem_data, 32'hA1B2C3D4);
        idle(1'b0);

        // Load timeout
        access(1'b1, 1'b0, 32'h40, 4'b1111, 32'h0, 0, 32'h0, 1'b0);
        #3;
        check("timeout stall cycles", stall_cnt, 32'd5);
        idle(1'b0);
        #3;
        check("timeout err pulses", err_cnt, 32'd1);
        check("timeout raw literal", raw_mem_data, 32'h0);

        // Back-to-back loads with stray acks in DONE
        req_rises = 0;
        access(1'b1, 1'b0, 32'h0, 4'b1111, 32'h0, 1, 32'h11111111, 1'b1);
        access(1'b1, 1'b0, 32'h4, 4'b1111, 32'h0, 1, 32'h22222222, 1'b1);
        idle(1'b1);
        #3;
        check("b2b req assertions", req_rises, 32'd2);
        check("b2b raw literal", raw_mem_data, 32'h22222222);

        // Empty lane mask ignored; read+write together issues a write
        req_rises = 0;
        access(1'b1, 1'b0, 32'h8, 4'b0000, 32'h0, 1, 32'h33333333, 1'b0);
        idle(1'b0);
        #3;
        check("empty mask req count", req_rises, 32'd0);
        access(1'b1, 1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 2, 32'h99999999, 1'b0);
        #3;
        check("rdwr raw literal", raw_mem_data, 32'h22222222);
        idle(1'b0);

        // Asynchronous reset in the middle of a load
        begin
            exp_t e;
            e = '0;  e.raw = m_raw;  e.st = S_IDLE;  e.stall = 1'b1;
            step(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 32'h0, e);
            e = '0;  e.req = 1'b1;  e.addr = 32'h100;  e.be = 4'b1111;  e.chk_bus = 1'b1;
            e.stall = 1'b1;  e.st = S_REQ;  e.raw = m_raw;
            step(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 32'h0, e);
            step(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 32'h0, e);
        end
        #3;
        rst = 1'b0;
        #1;
        check("midreset bus_req", {31'd0, bus_req}, 32'd0);
        check("midreset mem_stall", {31'd0, mem_stall}, 32'd0);
        check("midreset bus_addr", bus_addr, 32'd0);
        check("midreset bus_be", {28'd0, bus_be}, 32'd0);
        check("midreset raw", raw_mem_data, 32'd0);
        check("midreset state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        ReadMem = 1'b0;
        #2;
        rst = 1'b1;
        m_raw = 32'h0;
        idle(1'b0);
        access(1'b1, 1'b0, 32'h200, 4'b0010, 32'h0, 2, 32'h0BADF00D, 1'b0);
        idle(1'b0);
        #3;
        check("post-reset raw literal", raw_mem_data, 32'h0BADF00D);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
